freq_mode_detector: RTL and testbench
=====================================

# freq_mode_detector

Measures the period of an incoming square wave and classifies it as one of the four blink rates our clock-divider/mode-mux block produces (1, 2, 5, 10 Hz). It is the receiving end of that mode-select path: placed on a second board, or looped back on the same FPGA, it recovers the 2-bit mode from the waveform alone. Outputs drive LEDs and 7-segment display logic directly.

## Interface
- CLK_HZ, 50_000_000: system clock frequency in Hz; nominal periods P0..P3 = CLK_HZ, CLK_HZ/2, CLK_HZ/5, CLK_HZ/10 cycles.
- TOL_DIV, 16: acceptance window half-width is Pk/TOL_DIV cycles; must be >= 8.
- FILT_CYC, 4: input stability count, used only when the filter macro is defined.
- clk  in  1  system clock; everything runs on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sig_in  in  1  asynchronous square wave to classify.
- mode  out  2  decoded rate: 00=1 Hz, 01=2 Hz, 10=5 Hz, 11=10 Hz.
- valid  out  1  high while the last measured period matched a window and no timeout has occurred.
- err  out  1  one-cycle pulse when a measured period matches no window.

## Operation
- Front end: 2-FF synchronizer, then rising-edge detect producing a one-cycle `rise`.
- Period counter `cnt`, width clog2(TMAX+1), where TMAX = P0 + P0/TOL_DIV + 1.
  - On `rise`, `cnt` loads 1.
  - Otherwise it increments, saturating at TMAX.
  - At a `rise`, the value of `cnt` equals the cycles since the previous `rise`; this value is P.
- FSM states:
  - SEARCH (reset state): wait for the first `rise`. Go to MEASURE and load `cnt`. No classification, outputs unchanged.
  - MEASURE, on `rise`: classify P. If |P - Pk| <= Pk/TOL_DIV for some k, set mode<=k and valid<=1. Otherwise set err<=1 for one cycle and valid<=0, with mode held. Stay in MEASURE.
  - MEASURE, when `cnt` reaches TMAX with no `rise`: timeout. Set valid<=0 and return to SEARCH.
- Window arithmetic: window bounds are unsigned, computed at elaboration. With TOL_DIV >= 8 no two windows overlap, so at most one k matches.
- Boundary conditions:
  - A `rise` in the same cycle that `cnt` hits TMAX is a measured period, not a timeout: P=TMAX gives an err pulse and the FSM stays in MEASURE.
  - Exactly Pk ± Pk/TOL_DIV is accepted. One cycle further out is rejected.
  - A constant-high or constant-low input always times out.
  - Reset mid-measurement clears everything. The first edge after reset or after a timeout never produces a result.

## Timing
- Reset values: mode=00, valid=0, err=0, FSM=SEARCH, cnt=0.
- Latency: if sig_in is first sampled high at clock edge k, `rise` is asserted in cycle k+2. mode, valid and err update on edge k+3. With the filter macro defined, add FILT_CYC cycles.
- err is never high for two consecutive cycles.
- valid falls on the clock edge after `cnt` reaches TMAX.
- Minimum detectable gap between edges: 2 cycles. Shorter pulses are lost in the synchronizer.

## Configuration
- FREQ_DET_GLITCH_FILTER_EN
  - Defined: a filter between the synchronizer and the edge detect. The filtered level changes only after the synchronized input has differed from it for FILT_CYC consecutive cycles, so glitches shorter than FILT_CYC cycles are ignored.
  - Not defined: the filter is absent. The synchronizer output feeds the edge detect directly and FILT_CYC is unused.

## Structure
- Package freq_det_pkg:
  - Mode encoding constants MODE_1HZ..MODE_10HZ.
  - FSM state encoding.
  - A function returning Pk for a given CLK_HZ and index.
- Sub-module sig_sync_edge: synchronizer, optional filter and rising-edge detect; outputs `rise`.
- Top level: period counter, window comparators and FSM.

## Test plan
All scenarios use CLK_HZ=1000, TOL_DIV=16, which gives P=1000/500/200/100, half-windows 62/31/12/6 and TMAX=1063.
- 10 Hz square wave, period 100 cycles: valid rises 3 cycles after the 2nd sampled rising edge with mode=11. The 1st edge gives no output.
- Switch from a 200-cycle to a 500-cycle period mid-stream: mode goes 10 -> 01 at the first 500-cycle measurement, with no err.
- Periods of 106 and 94: accepted as mode=11. Periods of 107 and 93: one err pulse each, valid=0.
- Input held low after a valid lock: valid drops 1063 cycles after the last `rise`, then 2 more edges are needed to regain it.
- Reset asserted mid-period while valid=1: next cycle mode=00 and valid=0. Relock happens only after two post-reset edges.
- With FREQ_DET_GLITCH_FILTER_EN and FILT_CYC=4: 3-cycle glitches injected into a 200-cycle wave give no err and no mode change. Without the macro, the same stimulus produces an err pulse.

Source files
------------

// File: rtl/freq_det_pkg.sv
// freq_det_pkg: mode encodings, FSM state type and nominal period helper
// shared by the frequency mode detector and its front end.
package freq_det_pkg;

    localparam logic [1:0] MODE_1HZ  = 2'b00;
    localparam logic [1:0] MODE_2HZ  = 2'b01;
    localparam logic [1:0] MODE_5HZ  = 2'b10;
    localparam logic [1:0] MODE_10HZ = 2'b11;

    typedef enum logic {
        ST_SEARCH  = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // Nominal period in clock cycles of blink rate idx (1, 2, 5, 10 Hz).
    function automatic int unsigned period_cycles(
        input int unsigned clk_hz,
        input int unsigned idx
    );
        case (idx)
            0:       return clk_hz;
            1:       return clk_hz / 2;
            2:       return clk_hz / 5;
            default: return clk_hz / 10;
        endcase
    endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// sig_sync_edge: 2-FF synchronizer, optional glitch filter and registered
// rising-edge detect.
// Ports: i_clk, i_reset (sync, active high), i_sig (async in),
//        o_rise (one-cycle pulse per rising edge of the cleaned level).
// Macro FREQ_DET_GLITCH_FILTER_EN enables the FILT_CYC-cycle filter.
module sig_sync_edge #(
    parameter int unsigned FILT_CYC = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_rise;
    logic w_level;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
        end
    end

`ifdef FREQ_DET_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_CYC + 1);

    logic [FW-1:0] r_fcnt;
    logic          r_filt;

    // The filtered level flips on the FILT_CYC-th consecutive cycle in
    // which the synchronized input disagrees with it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fcnt <= '0;
            r_filt <= 1'b0;
        end else if (r_sync2 != r_filt) begin
            if (r_fcnt == FW'(FILT_CYC - 1)) begin
                r_filt <= r_sync2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end else begin
            r_fcnt <= '0;
        end
    end

    assign w_level = r_filt;
`else
    logic w_unused_filt;
    assign w_unused_filt = ^FILT_CYC;
    assign w_level       = r_sync2;
`endif

    // Registered edge pulse keeps the FSM input free of combinational paths.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= w_level;
            r_rise <= w_level & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/freq_mode_detector.sv
// freq_mode_detector: measures the period of a square wave and classifies
// it as one of the 1/2/5/10 Hz blink rates.
// Ports: i_clk, i_reset (sync, active high), i_sig_in (async),
//        o_mode (00=1Hz 01=2Hz 10=5Hz 11=10Hz), o_valid (locked),
//        o_err (one-cycle pulse on an unmatched period).
// Macro FREQ_DET_GLITCH_FILTER_EN enables the front-end glitch filter.
module freq_mode_detector
    import freq_det_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TOL_DIV  = 16,
    parameter int unsigned FILT_CYC = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sig_in,
    output logic [1:0] o_mode,
    output logic       o_valid,
    output logic       o_err
);

    localparam int unsigned P0 = period_cycles(CLK_HZ, 0);
    localparam int unsigned P1 = period_cycles(CLK_HZ, 1);
    localparam int unsigned P2 = period_cycles(CLK_HZ, 2);
    localparam int unsigned P3 = period_cycles(CLK_HZ, 3);

    localparam int unsigned TMAX = P0 + P0 / TOL_DIV + 1;
    localparam int          CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] TMAX_C = CW'(TMAX);

    localparam logic [CW-1:0] LO0 = CW'(P0 - P0 / TOL_DIV);
    localparam logic [CW-1:0] HI0 = CW'(P0 + P0 / TOL_DIV);
    localparam logic [CW-1:0] LO1 = CW'(P1 - P1 / TOL_DIV);
    localparam logic [CW-1:0] HI1 = CW'(P1 + P1 / TOL_DIV);
    localparam logic [CW-1:0] LO2 = CW'(P2 - P2 / TOL_DIV);
    localparam logic [CW-1:0] HI2 = CW'(P2 + P2 / TOL_DIV);
    localparam logic [CW-1:0] LO3 = CW'(P3 - P3 / TOL_DIV);
    localparam logic [CW-1:0] HI3 = CW'(P3 + P3 / TOL_DIV);

    logic          w_rise;
    logic [CW-1:0] r_cnt;
    logic [3:0]    w_hit;
    logic          w_match;
    logic [1:0]    w_mode;

    state_t        r_state;
    logic [1:0]    r_mode;
    logic          r_valid;
    logic          r_err;

    sig_sync_edge #(
        .FILT_CYC (FILT_CYC)
    ) u_front (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (i_sig_in),
        .o_rise  (w_rise)
    );

    // Cycles since the last rise; reads P when the next rise arrives.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= CW'(1);
        end else if (r_cnt != TMAX_C) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_hit[0] = (r_cnt >= LO0) && (r_cnt <= HI0);
    assign w_hit[1] = (r_cnt >= LO1) && (r_cnt <= HI1);
    assign w_hit[2] = (r_cnt >= LO2) && (r_cnt <= HI2);
    assign w_hit[3] = (r_cnt >= LO3) && (r_cnt <= HI3);
    assign w_match  = |w_hit;

    // Windows never overlap for TOL_DIV >= 8, so at most one hit is set.
    always_comb begin
        w_mode = MODE_1HZ;
        unique case (1'b1)
            w_hit[0]: w_mode = MODE_1HZ;
            w_hit[1]: w_mode = MODE_2HZ;
            w_hit[2]: w_mode = MODE_5HZ;
            w_hit[3]: w_mode = MODE_10HZ;
            default:  w_mode = MODE_1HZ;
        endcase
    end

    // A rise takes priority over timeout, so P == TMAX is classified
    // (and rejected) rather than treated as a lost signal.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_SEARCH;
            r_mode  <= MODE_1HZ;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                ST_SEARCH: begin
                    if (w_rise) begin
                        r_state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        if (w_match) begin
                            r_mode  <= w_mode;
                            r_valid <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                            r_valid <= 1'b0;
                        end
                    end else if (r_cnt == TMAX_C) begin
                        r_valid <= 1'b0;
                        r_state <= ST_SEARCH;
                    end
                end
                default: r_state <= ST_SEARCH;
            endcase
        end
    end

    assign o_mode  = r_mode;
    assign o_valid = r_valid;
    assign o_err   = r_err;

endmodule

// File: tb/tb_freq_mode_detector.sv
// tb_freq_mode_detector: directed bench for freq_mode_detector with
// CLK_HZ=1000, TOL_DIV=16 (P=1000/500/200/100, TMAX=1063).
module tb_freq_mode_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig;
    logic [1:0] mode;
    logic       valid;
    logic       err;

    always #5 clk = ~clk;

    freq_mode_detector #(
        .CLK_HZ   (1000),
        .TOL_DIV  (16),
        .FILT_CYC (4)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_sig_in (sig),
        .o_mode   (mode),
        .o_valid  (valid),
        .o_err    (err)
    );

`ifdef FREQ_DET_GLITCH_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    int   errors  = 0;
    int   checks  = 0;
    int   err_cnt = 0;
    int   consec  = 0;
    logic prev_err = 1'b0;

    always @(negedge clk) begin
        if (err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            if (prev_err) consec <= consec + 1;
        end
        prev_err <= (err === 1'b1);
    end

    typedef struct {
        int         period;
        logic [1:0] mode;
        logic       valid;
        int         errs;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rise();
        sig = 1'b1;
        repeat (10) cyc();
        sig = 1'b0;
    endtask

    task automatic gap(input int p);
        repeat (p - 10) cyc();
    endtask

    initial begin
        int e0;

        tbl[0]  = '{100,  2'd3, 1'b1, 0};
        tbl[1]  = '{106,  2'd3, 1'b1, 0};
        tbl[2]  = '{94,   2'd3, 1'b1, 0};
        tbl[3]  = '{107,  2'd3, 1'b0, 1};
        tbl[4]  = '{100,  2'd3, 1'b1, 0};
        tbl[5]  = '{93,   2'd3, 1'b0, 1};
        tbl[6]  = '{200,  2'd2, 1'b1, 0};
        tbl[7]  = '{188,  2'd2, 1'b1, 0};
        tbl[8]  = '{187,  2'd2, 1'b0, 1};
        tbl[9]  = '{212,  2'd2, 1'b1, 0};
        tbl[10] = '{213,  2'd2, 1'b0, 1};
        tbl[11] = '{200,  2'd2, 1'b1, 0};
        tbl[12] = '{500,  2'd1, 1'b1, 0};
        tbl[13] = '{469,  2'd1, 1'b1, 0};
        tbl[14] = '{531,  2'd1, 1'b1, 0};
        tbl[15] = '{532,  2'd1, 1'b0, 1};
        tbl[16] = '{1000, 2'd0, 1'b1, 0};
        tbl[17] = '{1062, 2'd0, 1'b1, 0};
        tbl[18] = '{938,  2'd0, 1'b1, 0};
        tbl[19] = '{937,  2'd0, 1'b0, 1};
        tbl[20] = '{1063, 2'd0, 1'b0, 1};
        tbl[21] = '{100,  2'd3, 1'b1, 0};

        sig = 1'b0;
        rst = 1'b1;
        repeat (3) cyc();
        check("reset_mode", int'(mode), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b0;
        repeat (5) cyc();

        // First edge only arms the measurement.
        do_rise();
        check("first_edge_valid", int'(valid), 0);
        check("first_edge_mode", int'(mode), 0);
        check("first_edge_errs", err_cnt, 0);

        // Exact latency of the second edge at 100 cycles.
        gap(100);
        sig = 1'b1;
        repeat (LAT) cyc();
        check("lat_before_valid", int'(valid), 0);
        cyc();
        check("lat_valid", int'(valid), 1);
        check("lat_mode", int'(mode), 3);
        repeat (10 - LAT - 1) cyc();
        sig = 1'b0;

        for (int i = 0; i < 22; i++) begin
            gap(tbl[i].period);
            e0 = err_cnt;
            do_rise();
            check($sformatf("vec%0d_p%0d_mode", i, tbl[i].period),
                  int'(mode), int'(tbl[i].mode));
            check($sformatf("vec%0d_p%0d_valid", i, tbl[i].period),
                  int'(valid), int'(tbl[i].valid));
            check($sformatf("vec%0d_p%0d_errs", i, tbl[i].period),
                  err_cnt - e0, tbl[i].errs);
        end

        // Timeout: last rise, then input held low.
        gap(100);
        e0 = err_cnt;
        sig = 1'b1;
        for (int n = 1; n <= LAT + 1064; n++) begin
            cyc();
            if (n == 10) sig = 1'b0;
            if (n == LAT + 1) check("to_locked", int'(valid), 1);
            if (n == LAT + 1063) check("to_still_valid", int'(valid), 1);
            if (n == LAT + 1064) check("to_dropped", int'(valid), 0);
        end
        check("to_errs", err_cnt - e0, 0);
        check("to_mode_held", int'(mode), 3);
        repeat (30) cyc();
        do_rise();
        check("to_first_edge_valid", int'(valid), 0);
        gap(100);
        do_rise();
        check("to_relock_valid", int'(valid), 1);
        check("to_relock_mode", int'(mode), 3);

        // Reset in the middle of a locked 200-cycle period.
        gap(200);
        do_rise();
        check("rst_pre_mode", int'(mode), 2);
        repeat (50) cyc();
        rst = 1'b1;
        cyc();
        check("rst_mid_mode", int'(mode), 0);
        check("rst_mid_valid", int'(valid), 0);
        rst = 1'b0;
        repeat (20) cyc();
        do_rise();
        check("rst_first_edge_valid", int'(valid), 0);
        gap(200);
        do_rise();
        check("rst_relock_valid", int'(valid), 1);
        check("rst_relock_mode", int'(mode), 2);

        // 3-cycle glitches in the low phase of a 200-cycle wave.
        e0 = err_cnt;
        for (int g = 0; g < 3; g++) begin
            repeat (80) cyc();
            sig = 1'b1;
            repeat (3) cyc();
            sig = 1'b0;
            repeat (107) cyc();
            do_rise();
        end
`ifdef FREQ_DET_GLITCH_FILTER_EN
        check("glitch_errs", err_cnt - e0, 0);
        check("glitch_valid", int'(valid), 1);
        check("glitch_mode", int'(mode), 2);
`else
        check("glitch_errs", err_cnt - e0, 6);
        check("glitch_valid", int'(valid), 0);
        check("glitch_mode", int'(mode), 2);
`endif

        repeat (5) cyc();
        check("err_back_to_back", consec, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
